// File: rtl/motor_cmd_sched_if.sv
// Command/PWM bundle between the flight-control law,
// the motor command scheduler and the four PWM ramp blocks.
interface motor_cmd_sched_if;
  logic        arm;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_speed;
  logic [3:0]  pwm_busy;
  logic [63:0] speed_out;
  logic [3:0]  speed_oe;
  logic        armed;
  logic        fault;

  modport master (
    output arm,
    output cmd_valid,
    input  cmd_ready,
    output cmd_speed,
    output pwm_busy,
    input  speed_out,
    input  speed_oe,
    input  armed,
    input  fault
  );

  modport slave (
    input  arm,
    input  cmd_valid,
    output cmd_ready,
    input  cmd_speed,
    input  pwm_busy,
    output speed_out,
    output speed_oe,
    output armed,
    output fault
  );
endinterface

// File: rtl/motor_cmd_sched.sv
// Clamps 4-motor speed commands and strobes them out one motor
// at a time; handles arming and the command watchdog failsafe.
module motor_cmd_sched #(
  parameter int unsigned MIN_SPEED   = 256,
  parameter int unsigned MAX_CMD     = 62720,
  parameter int unsigned CMD_TIMEOUT = 2000000,
  parameter int unsigned WDOG_W      = 24
) (
  input logic               clk,
  input logic               rst,
  motor_cmd_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    DISARMED,
    IDLE,
    DISPATCH,
    FAILSAFE
  } state_t;

  localparam logic [15:0] MIN16 = 16'(MIN_SPEED);
  localparam logic [15:0] MAX16 = 16'(MAX_CMD);
  localparam logic [WDOG_W-1:0] WD_LAST = WDOG_W'(CMD_TIMEOUT - 1);

  state_t              state_q, state_d;
  state_t              ret_q, ret_d;
  logic [1:0]          idx_q, idx_d;
  logic [WDOG_W-1:0]   wd_q, wd_d;
  logic                fault_q, fault_d;
  logic [15:0]         sh_q [4];
  logic [15:0]         sh_d [4];
  logic [63:0]         out_q, out_d;
  logic [3:0]          oe_q, oe_d;
  logic                go_disarm;

  function automatic logic [15:0] clamp(input logic [15:0] v);
    if (v < MIN16)      return MIN16;
    else if (v > MAX16) return MAX16;
    else                return v;
  endfunction

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    idx_d     = idx_q;
    wd_d      = wd_q;
    fault_d   = fault_q;
    sh_d      = sh_q;
    out_d     = out_q;
    oe_d      = '0;
    go_disarm = 1'b0;
    unique case (state_q)
      DISARMED: begin
        if (bus.arm) begin
          state_d = IDLE;
          wd_d    = '0;
        end
      end
      IDLE: begin
        if (!bus.arm) begin
          go_disarm = 1'b1;
        end else if (bus.cmd_valid) begin
          for (int i = 0; i < 4; i++)
            sh_d[i] = clamp(bus.cmd_speed[16*i +: 16]);
          idx_d   = '0;
          ret_d   = IDLE;
          wd_d    = '0;
          state_d = DISPATCH;
        end else if (wd_q == WD_LAST) begin
          for (int i = 0; i < 4; i++)
            sh_d[i] = MIN16;
          fault_d = 1'b1;
          ret_d   = FAILSAFE;
          idx_d   = '0;
          state_d = DISPATCH;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      DISPATCH: begin
        // a disarm-targeted sequence always runs to completion
        if (!bus.arm && ret_q != DISARMED) begin
          go_disarm = 1'b1;
        end else if (!bus.pwm_busy[idx_q]) begin
          out_d[{idx_q, 4'b0000} +: 16] = sh_q[idx_q];
          oe_d[idx_q] = 1'b1;
          idx_d       = idx_q + 1'b1;
          if (idx_q == 2'd3)
            state_d = ret_q;
        end
      end
      FAILSAFE: begin
        if (!bus.arm)
          go_disarm = 1'b1;
      end
      default: state_d = DISARMED;
    endcase
    if (go_disarm) begin
      for (int i = 0; i < 4; i++)
        sh_d[i] = MIN16;
      idx_d   = '0;
      ret_d   = DISARMED;
      fault_d = 1'b0;
      state_d = DISPATCH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DISARMED;
      ret_q   <= DISARMED;
      idx_q   <= '0;
      wd_q    <= '0;
      fault_q <= 1'b0;
      out_q   <= {4{MIN16}};
      oe_q    <= '0;
      for (int i = 0; i < 4; i++)
        sh_q[i] <= MIN16;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      idx_q   <= idx_d;
      wd_q    <= wd_d;
      fault_q <= fault_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      for (int i = 0; i < 4; i++)
        sh_q[i] <= sh_d[i];
    end
  end

  assign bus.cmd_ready = (state_q == IDLE) && bus.arm;
  assign bus.armed     = (state_q == IDLE) ||
                         (state_q == DISPATCH && ret_q == IDLE);
  assign bus.fault     = fault_q;
  assign bus.speed_out = out_q;
  assign bus.speed_oe  = oe_q;

endmodule

// File: tb/tb_motor_cmd_sched.sv
// Self-checking bench for motor_cmd_sched: command vectors,
// busy stall, watchdog, disarm and async reset sequences.
module tb_motor_cmd_sched;

  localparam logic [15:0] MN = 16'd256;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  motor_cmd_sched_if bus ();

  motor_cmd_sched #(
    .MIN_SPEED  (256),
    .MAX_CMD    (62720),
    .CMD_TIMEOUT(16),
    .WDOG_W     (24)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int          motor;
    logic [15:0] val;
  } exp_t;

  typedef struct {
    logic [63:0] cmd;
    logic [63:0] exp;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic push_min4();
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{i, MN});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every strobe must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && bus.speed_oe != 4'b0000) begin
      exp_t e;
      chk("oe_onehot", 64'($countones(bus.speed_oe)), 64'd1);
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL sb_unexpected: oe=%b with nothing queued",
                 bus.speed_oe);
      end else begin
        e = exp_q.pop_front();
        chk("sb_oe", 64'(bus.speed_oe), 64'(4'b0001 << e.motor));
        chk("sb_val", 64'(bus.speed_out[16*e.motor +: 16]), 64'(e.val));
      end
    end
  end

  task automatic run_cmd(input logic [63:0] c, input logic [63:0] e);
    int n;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) begin
      total_cnt++;
      $display("FAIL ready_timeout: cmd_ready=%b required 1", bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_speed = c;
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{i, e[16*i +: 16]});
    tick();
    bus.cmd_valid = 1'b0;
    chk("acc_ready", 64'(bus.cmd_ready), 64'd0);
    chk("acc_oe", 64'(bus.speed_oe), 64'd0);
  endtask

  task automatic strobes4(input string tag);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk(tag, 64'(bus.speed_oe), 64'(4'b0001 << k));
      if (k < 3)
        chk({tag, "_rdy"}, 64'(bus.cmd_ready), 64'd0);
    end
  endtask

  initial begin
    int bad;
    vecs[0] = '{{16'd30000, 16'd100, 16'd65535, 16'd1000},
                {16'd30000, 16'd256, 16'd62720, 16'd1000}};
    vecs[1] = '{{16'd62721, 16'd255, 16'd62720, 16'd256},
                {16'd62720, 16'd256, 16'd62720, 16'd256}};
    vecs[2] = '{{16'd40000, 16'd65535, 16'd1, 16'd0},
                {16'd40000, 16'd62720, 16'd256, 16'd256}};
    vecs[3] = '{{16'd8000, 16'd7000, 16'd6000, 16'd5000},
                {16'd8000, 16'd7000, 16'd6000, 16'd5000}};

    rst           = 1'b1;
    bus.arm       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_speed = '0;
    bus.pwm_busy  = 4'b0000;
    #1;
    chk("rst_oe", 64'(bus.speed_oe), 64'd0);
    chk("rst_ready", 64'(bus.cmd_ready), 64'd0);
    chk("rst_armed", 64'(bus.armed), 64'd0);
    chk("rst_fault", 64'(bus.fault), 64'd0);
    chk("rst_lanes", bus.speed_out, {4{MN}});

    tick();
    tick();
    rst     = 1'b0;
    bus.arm = 1'b1;
    tick();
    chk("arm_ready", 64'(bus.cmd_ready), 64'd1);
    chk("arm_armed", 64'(bus.armed), 64'd1);
    chk("arm_oe", 64'(bus.speed_oe), 64'd0);
    chk("arm_lanes", bus.speed_out, {4{MN}});

    for (int v = 0; v < 4; v++) begin
      run_cmd(vecs[v].cmd, vecs[v].exp);
      strobes4("vec_oe");
      chk("vec_lanes", bus.speed_out, vecs[v].exp);
      chk("vec_ready", 64'(bus.cmd_ready), 64'd1);
    end

    // motor 1 busy for 10 cycles after motor 0 is loaded
    bus.pwm_busy = 4'b0010;
    run_cmd({16'd4444, 16'd3333, 16'd2222, 16'd1111},
            {16'd4444, 16'd3333, 16'd2222, 16'd1111});
    tick();
    chk("busy_m0", 64'(bus.speed_oe), 64'd1);
    bad = 0;
    repeat (10) begin
      tick();
      if (bus.speed_oe != 4'b0000)
        bad++;
    end
    chk("busy_gap", 64'(bad), 64'd0);
    bus.pwm_busy = 4'b0000;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("busy_oe", 64'(bus.speed_oe), 64'(4'b0001 << k));
    end

    // watchdog: 16th idle cycle trips
    repeat (15) tick();
    chk("wd_pre_fault", 64'(bus.fault), 64'd0);
    chk("wd_pre_ready", 64'(bus.cmd_ready), 64'd1);
    tick();
    chk("wd_fault", 64'(bus.fault), 64'd1);
    chk("wd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("wd_armed", 64'(bus.armed), 64'd0);
    push_min4();
    strobes4("wd_oe");
    chk("fs_ready", 64'(bus.cmd_ready), 64'd0);
    chk("fs_fault", 64'(bus.fault), 64'd1);
    chk("fs_lanes", bus.speed_out, {4{MN}});
    tick();
    chk("fs_hold", 64'(bus.speed_oe), 64'd0);
    bus.arm = 1'b0;
    push_min4();
    tick();
    chk("fs_dis_fault", 64'(bus.fault), 64'd0);
    strobes4("fs_dis_oe");
    chk("dis_armed", 64'(bus.armed), 64'd0);
    chk("dis_ready", 64'(bus.cmd_ready), 64'd0);
    bus.arm = 1'b1;
    tick();
    chk("rearm_ready", 64'(bus.cmd_ready), 64'd1);

    // command lands on the exact expiry cycle
    run_cmd({16'd1200, 16'd1100, 16'd1000, 16'd900},
            {16'd1200, 16'd1100, 16'd1000, 16'd900});
    strobes4("pre_race");
    repeat (15) tick();
    chk("race_ready", 64'(bus.cmd_ready), 64'd1);
    run_cmd({16'd2400, 16'd2300, 16'd2200, 16'd2100},
            {16'd2400, 16'd2300, 16'd2200, 16'd2100});
    chk("race_fault", 64'(bus.fault), 64'd0);
    strobes4("race_oe");
    chk("race_lanes", bus.speed_out,
        {16'd2400, 16'd2300, 16'd2200, 16'd2100});

    // disarm after motor 1, re-arm ignored until DISARMED
    run_cmd({16'd9300, 16'd9200, 16'd9100, 16'd9000},
            {16'd9300, 16'd9200, 16'd9100, 16'd9000});
    tick();
    chk("dm_m0", 64'(bus.speed_oe), 64'd1);
    tick();
    chk("dm_m1", 64'(bus.speed_oe), 64'd2);
    bus.arm = 1'b0;
    tick();
    chk("dm_gap", 64'(bus.speed_oe), 64'd0);
    chk("dm_armed", 64'(bus.armed), 64'd0);
    exp_q.delete();
    push_min4();
    bus.arm = 1'b1;
    strobes4("dm_oe");
    chk("dm_end_ready", 64'(bus.cmd_ready), 64'd0);
    chk("dm_end_armed", 64'(bus.armed), 64'd0);
    chk("dm_lanes", bus.speed_out, {4{MN}});
    tick();
    chk("dm_rearm", 64'(bus.cmd_ready), 64'd1);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    // asynchronous reset in the middle of a dispatch
    run_cmd({16'd5400, 16'd5300, 16'd5200, 16'd5100},
            {16'd5400, 16'd5300, 16'd5200, 16'd5100});
    tick();
    chk("ar_m0", 64'(bus.speed_oe), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("ar_oe", 64'(bus.speed_oe), 64'd0);
    chk("ar_ready", 64'(bus.cmd_ready), 64'd0);
    chk("ar_armed", 64'(bus.armed), 64'd0);
    chk("ar_fault", 64'(bus.fault), 64'd0);
    chk("ar_lanes", bus.speed_out, {4{MN}});
    tick();
    rst = 1'b0;
    tick();
    chk("ar_rearm", 64'(bus.cmd_ready), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/motor_cmd_sched.md
Name: motor_cmd_sched

Overview:
- Sits between the flight-control law and four per-motor PWM speed ramp blocks.
- Accepts one 4-motor speed command at a time and clamps each value to the legal range.
- Dispatches the values one motor at a time, in order 0..3, using each PWM block's busy/oe handshake.
- Adds arming and a command watchdog: loss of commands or disarm drives every motor to MIN_SPEED.

Parameters:
- MIN_SPEED, 256, floor speed; also the disarm and failsafe value.
- MAX_CMD, 62720, ceiling speed after clamping.
- CMD_TIMEOUT, 2000000, armed-idle cycles without an accepted command before failsafe (20 ms at 100 MHz).
- WDOG_W, 24, watchdog counter width; must hold CMD_TIMEOUT.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- arm  input  1  level; 1 requests armed operation.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
- cmd_speed  input  64  motor i at [16i+15:16i].
- pwm_busy  input  4  busy flag from each PWM block.
- speed_out  output  64  per-motor speed to the PWM blocks, packed like cmd_speed.
- speed_oe  output  4  one-cycle load strobe per motor.
- armed  output  1  1 in IDLE, or in DISPATCH with return target IDLE.
- fault  output  1  watchdog tripped; sticky until disarm.

Behaviour:
- States: DISARMED, IDLE, DISPATCH, FAILSAFE. Registers: shadow sh[0..3], idx (2 bit), return target ret, watchdog wd.
- Reset values:
  - state=DISARMED, sh[*]=MIN_SPEED, speed_out lanes=MIN_SPEED, speed_oe=0.
  - cmd_ready=0, armed=0, fault=0, wd=0, idx=0.
- cmd_ready is a combinational decode: 1 only when state==IDLE && arm==1.
- DISARMED:
  - If arm==1: go to IDLE and clear wd.
  - Otherwise stay.
- IDLE:
  - Accept (cmd_valid && cmd_ready): sh[i] <= clamp(cmd_speed lane i), idx<=0, ret<=IDLE, wd<=0, go to DISPATCH.
  - Otherwise wd increments. When wd reaches CMD_TIMEOUT-1: sh[*]<=MIN_SPEED, fault<=1, ret<=FAILSAFE, idx<=0, go to DISPATCH.
  - An accept in the same cycle as expiry wins; no fault is raised.
- clamp(v) = MIN_SPEED if v<MIN_SPEED, MAX_CMD if v>MAX_CMD, otherwise v. Compare unsigned at 16 bits; no wrap.
- DISPATCH:
  - Each cycle, if pwm_busy[idx]==0: speed_out lane idx <= sh[idx], speed_oe[idx] <= 1 for exactly one cycle, then idx increments.
  - If pwm_busy[idx]==1: wait; no strobe.
  - After motor 3 is strobed, go to ret.
  - At most one speed_oe bit is high in any cycle.
  - Best case is 4 consecutive cycles. Latency from accept to the first strobe is 1 cycle.
- Disarm (arm==0 sampled in IDLE, FAILSAFE, or DISPATCH with ret!=DISARMED):
  - sh[*]<=MIN_SPEED, idx<=0, ret<=DISARMED, fault<=0, go to DISPATCH. The in-progress sequence is abandoned.
  - In DISPATCH with ret==DISARMED, arm==0 has no further effect; the sequence is not restarted.
- arm==1 during a DISARMED-targeted DISPATCH is ignored until DISARMED is reached.
- FAILSAFE: cmd_ready=0, fault=1. The only exit is arm==0, via the disarm path above.
- speed_out lanes hold their last strobed value between strobes.
- Reset mid-operation returns everything to reset values immediately (asynchronous).

Test Plan:
- Reset then arm=1 -> next cycle state IDLE, cmd_ready=1, armed=1, speed_oe=0, speed_out lanes=256.
- Command {1000,70000-clamped-in-source:65535,100,30000}, pwm_busy=0 -> speed_oe=0001,0010,0100,1000 in 4 consecutive cycles starting 1 cycle after accept; lanes 1000,62720,256,30000; cmd_ready=0 throughout, back to 1 after.
- pwm_busy[1] held high 10 cycles during dispatch -> motor 0 strobed, 10-cycle gap, then motors 1,2,3 strobed in order; never two oe bits in the same cycle.
- CMD_TIMEOUT=16, armed, no command -> on the 16th idle cycle fault=1; four strobes of 256; state FAILSAFE with cmd_ready=0; arm=0 -> four 256 strobes, fault=0, DISARMED.
- arm dropped after motor 1 strobed in a normal dispatch -> restart from motor 0 with four 256 strobes, then DISARMED; arm re-raised mid-sequence is ignored until completion.
- cmd_valid in the exact cycle the watchdog expires -> command accepted, fault stays 0, normal dispatch; async rst mid-dispatch -> all outputs at reset values in the same cycle.
